// File: rtl/dsp_delay_sched_pkg.sv
// Shared types and constants for the DSP48E1 delay-counter scheduler.
// The optional watchdog is enabled with DSP_DELAY_SCHED_TIMEOUT_EN.
package dsp_delay_sched_pkg;

    localparam int DLY_W         = 16;
    localparam int LOAD_WAIT_DEF = 4;
    localparam int STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        ARB,
        LOAD,
        SETTLE,
        RUN,
        DONE
    } state_t;

    // Index of the (single) set bit of a one-hot vector of up to 8 bits.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dsp_delay_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins,
// searching upward and wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    logic [$clog2(N)-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = $clog2(N)'((int'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_delay_sched.sv
// Shares one external dsp_delay counter among NREQ requesters: round-robin
// arbitration, reload/settle/count sequencing, done reporting.
// Optional watchdog on RUN is enabled with DSP_DELAY_SCHED_TIMEOUT_EN.
module dsp_delay_sched
    import dsp_delay_sched_pkg::*;
#(
    parameter int NREQ       = 4,
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
    parameter int TMO_MARGIN = 8,
`endif
    parameter int LOAD_WAIT  = LOAD_WAIT_DEF
) (
    input  logic                  fast_clk_i,
    input  logic                  fast_rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [DLY_W*NREQ-1:0] req_delay_i,
    output logic [NREQ-1:0]       grant_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  busy_o,
    output logic                  dly_rst_o,
    output logic                  dly_enable_o,
    output logic [DLY_W-1:0]      dly_delay_o,
    input  logic                  dly_reached_i,
    output logic                  timeout_o
);

    localparam int PW = $clog2(NREQ);

    // Requester handshake: req_i[i] is a level held until done_o[i] pulses;
    // grant_o[i] marks ownership; dropping req_i[i] while granted aborts.
    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [NREQ-1:0]   arb_grant;
    logic              arb_valid;
    logic [2:0]        win_idx;
    logic [DLY_W-1:0]  win_delay;
    logic [7:0]        settle_cnt;
    logic              abort;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_i),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        win_delay = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) win_delay = req_delay_i[DLY_W*i +: DLY_W];
        end
        win_idx = onehot_idx(8'(arb_grant));
        if (win_idx == 3'(NREQ - 1)) ptr_next = '0;
        else                         ptr_next = PW'(win_idx + 3'd1);
    end

    assign abort = ~|(req_i & grant_o);

`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
    logic [DLY_W:0] wdog;
    logic [DLY_W:0] wdog_limit;
    assign wdog_limit = {1'b0, dly_delay_o} + (DLY_W+1)'(TMO_MARGIN - 1);
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge fast_clk_i) begin
        if (!fast_rst_n_i) begin
            state        <= ARB;
            ptr          <= '0;
            grant_o      <= '0;
            done_o       <= '0;
            busy_o       <= 1'b0;
            dly_rst_o    <= 1'b0;
            dly_enable_o <= 1'b0;
            dly_delay_o  <= '0;
            settle_cnt   <= '0;
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
            wdog         <= '0;
            timeout_o    <= 1'b0;
`endif
        end else begin
            done_o    <= '0;
            dly_rst_o <= 1'b0;
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            // Aborts share one exit path from every counting state.
            if ((state == LOAD || state == SETTLE || state == RUN) && abort) begin
                grant_o      <= '0;
                dly_enable_o <= 1'b0;
                busy_o       <= 1'b0;
                state        <= ARB;
            end else begin
                case (state)
                    ARB: begin
                        if (arb_valid) begin
                            grant_o     <= arb_grant;
                            dly_delay_o <= win_delay;
                            ptr         <= ptr_next;
                            dly_rst_o   <= 1'b1;
                            busy_o      <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == 8'(LOAD_WAIT - 1)) begin
                            // A zero delay matches at counter reset, so never run it.
                            state <= (dly_delay_o == '0) ? DONE : RUN;
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
                            wdog  <= '0;
`endif
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                    RUN: begin
                        if (dly_reached_i) begin
                            dly_enable_o <= 1'b0;
                            state        <= DONE;
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
                        end else if (wdog == wdog_limit) begin
                            timeout_o    <= 1'b1;
                            dly_enable_o <= 1'b0;
                            grant_o      <= '0;
                            busy_o       <= 1'b0;
                            state        <= ARB;
`endif
                        end else begin
                            dly_enable_o <= 1'b1;
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
                            wdog         <= wdog + 1'b1;
`endif
                        end
                    end
                    DONE: begin
                        done_o  <= grant_o;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= ARB;
                    end
                    default: state <= ARB;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp_delay_sched.sv
// Bench for dsp_delay_sched with a behavioural dsp_delay counter beside it.
// Define DSP_DELAY_SCHED_TIMEOUT_EN to exercise the watchdog build.
module tb_dsp_delay_sched;

    localparam int NREQ = 4;
    localparam int LW   = 4;
    localparam int W    = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [63:0]     req_delay;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            dly_rst;
    logic            dly_enable;
    logic [15:0]     dly_delay;
    logic            dly_reached;
    logic            timeout;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dsp_delay_sched #(.NREQ(NREQ), .LOAD_WAIT(LW)) dut (
        .fast_clk_i    (clk),
        .fast_rst_n_i  (rst_n),
        .req_i         (req),
        .req_delay_i   (req_delay),
        .grant_o       (grant),
        .done_o        (done),
        .busy_o        (busy),
        .dly_rst_o     (dly_rst),
        .dly_enable_o  (dly_enable),
        .dly_delay_o   (dly_delay),
        .dly_reached_i (dly_reached),
        .timeout_o     (timeout)
    );

    // ---------------- dsp_delay model: 3-stage reset pipe, registered match ----------------
    logic [2:0]  rp        = '0;
    logic [15:0] cnt_m     = '0;
    logic        reached_m = 1'b0;
    logic        tie_low   = 1'b0;

    always @(posedge clk) begin
        rp <= {rp[1:0], dly_rst};
        if (rp[2]) begin
            cnt_m     <= '0;
            reached_m <= 1'b0;
        end else if (dly_enable) begin
            cnt_m     <= cnt_m + 16'd1;
            reached_m <= ((cnt_m + 16'd1) == dly_delay);
        end
    end
    assign dly_reached = reached_m & ~tie_low;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int unsigned     cyc = 0;
    int unsigned     g_cyc = 0;
    int unsigned     rst_cnt = 0;
    int unsigned     en_cnt = 0;
    logic [NREQ-1:0] prev_grant = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        rst_cnt += 32'(dly_rst);
        en_cnt  += 32'(dly_enable);
        if (grant != '0 && prev_grant == '0) g_cyc = cyc;
        prev_grant = grant;
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("done_sb", {8'd0, 8'(done), 16'(cyc - g_cyc)}, 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int i, input logic [15:0] d);
        req_delay[16*i +: 16] = d;
    endtask

    task automatic push_exp(input int i, input int lat);
        logic [7:0] oh;
        oh = 8'd1 << i;
        exp_q.push_back({oh, 16'(lat)});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Waits for the expected done pulse and releases that request on the same cycle.
    task automatic wait_done(input logic [NREQ-1:0] exp_oh, input int budget, input bit release_req);
        int n;
        n = 0;
        while (done == '0 && n < budget) begin
            tick();
            n++;
        end
        if (done == '0) check("done_wait", 32'(done), 32'(exp_oh));
        else if (release_req) req = req & ~done;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned r0, e0, n;
        rst_n     = 1'b0;
        req       = '0;
        req_delay = '0;

        // 1: reset with all requests high
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_delay(i, 16'd50);
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_dly_rst", 32'(dly_rst), 32'd0);
        check("rst_enable",  32'(dly_enable), 32'd0);
        check("rst_delay",   32'(dly_delay), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();
        check("first_grant", 32'(grant), 32'b0001);
        check("first_dly_rst", 32'(dly_rst), 32'd1);
        check("first_delay", 32'(dly_delay), 32'd50);
        req = '0;
        tick();
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);

        // 2: single request, delay 10
        apply_reset();
        set_delay(2, 16'd10);
        r0 = rst_cnt; e0 = en_cnt;
        push_exp(2, 1 + 1 + LW + 10 + 2);
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'b0100);
        check("single_busy",  32'(busy), 32'd1);
        wait_done(4'b0100, 60, 1'b1);
        repeat (2) tick();
        check("single_rst_pulses", rst_cnt - r0, 32'd1);
        check("single_en_cycles",  en_cnt - e0, 32'd11);
        check("single_idle", 32'(busy), 32'd0);

        // 3: round robin over 4'b1011, delay 3
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_delay(i, 16'd3);
        push_exp(0, 11); push_exp(1, 11); push_exp(3, 11);
        push_exp(0, 11); push_exp(1, 11); push_exp(3, 11);
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_done(4'b1111, 40, 1'b0);
            if (k < 5) tick();
        end
        req = '0;
        repeat (2) tick();
        check("rr_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rr_idle_grant", 32'(grant), 32'd0);

        // 4: zero delay bypasses RUN
        apply_reset();
        set_delay(1, 16'd0);
        r0 = rst_cnt; e0 = en_cnt;
        push_exp(1, 1 + LW + 1);
        req = 4'b0010;
        wait_done(4'b0010, 30, 1'b1);
        repeat (2) tick();
        check("zero_en_cycles",  en_cnt - e0, 32'd0);
        check("zero_rst_pulses", rst_cnt - r0, 32'd1);

        // 5: abort in RUN, pending requester takes over
        apply_reset();
        set_delay(0, 16'd100);
        set_delay(3, 16'd2);
        req = 4'b1001;
        n = 0;
        while (!dly_enable && n < 40) begin tick(); n++; end
        check("abort_run_enable", 32'(dly_enable), 32'd1);
        check("abort_run_grant",  32'(grant), 32'b0001);
        repeat (4) tick();
        push_exp(3, 1 + 1 + LW + 2 + 2);
        req = 4'b1000;
        tick();
        check("abort5_grant",  32'(grant), 32'd0);
        check("abort5_enable", 32'(dly_enable), 32'd0);
        check("abort5_busy",   32'(busy), 32'd0);
        tick();
        check("abort5_next_grant", 32'(grant), 32'b1000);
        wait_done(4'b1000, 40, 1'b1);
        repeat (2) tick();
        check("abort5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: counter never reaches
        apply_reset();
        set_delay(2, 16'd20);
        tie_low = 1'b1;
        req = 4'b0100;
        tick();
        check("tmo_grant", 32'(grant), 32'b0100);
`ifdef DSP_DELAY_SCHED_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 100) begin tick(); n++; end
        req = '0;
        check("tmo_pulse",   32'(timeout), 32'd1);
        check("tmo_latency", 32'(n), 32'd33);
        check("tmo_grant_clr", 32'(grant), 32'd0);
        check("tmo_busy_clr",  32'(busy), 32'd0);
        tick();
        check("tmo_pulse_end", 32'(timeout), 32'd0);
`else
        repeat (80) tick();
        check("notmo_busy",    32'(busy), 32'd1);
        check("notmo_enable",  32'(dly_enable), 32'd1);
        check("notmo_timeout", 32'(timeout), 32'd0);
        check("notmo_grant",   32'(grant), 32'b0100);
        req = '0;
        tick();
        check("notmo_abort_grant", 32'(grant), 32'd0);
`endif
        tie_low = 1'b0;
        repeat (3) tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
